mem_wb_stage: RTL and testbench

// - MEM/WB pipeline register plus write-back stage. Sits directly downstream of the MEM stage.
// - Captures the memory read word, ALU result and PC+4 each cycle; honours stall (hold) and flush (bubble).
// - Performs load byte/half extraction with sign/zero extension.
// - Selects the register-file write value, driving write_data_WB back to the MEM store-data forwarding mux.

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/mem_wb_stage_load_align.sv | 41 ++++
 rtl/mem_wb_stage.sv | 153 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath width, write-back select
// encoding, load funct3 codes and the load misalignment rule.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Undefined load funct3 codes behave as LW, so they need word alignment.
    function automatic logic ld_misaligned(
        input logic [2:0] f3,
        input logic [1:0] addr
    );
        logic mis;
        case (f3)
            F3_LB, F3_LBU: mis = 1'b0;
            F3_LH, F3_LHU: mis = addr[0];
            default:       mis = (addr != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load alignment: selects the byte/half lane of a memory word and extends it.
// Ports: data_i (read word), addr_i (addr[1:0]), funct3_i -> data_o, misalign_o.
module load_align
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] data_i,
    input  logic [1:0]      addr_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o,
    output logic            misalign_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = data_i[7:0];
        case (addr_i)
            2'b00:   byte_v = data_i[7:0];
            2'b01:   byte_v = data_i[15:8];
            2'b10:   byte_v = data_i[23:16];
            default: byte_v = data_i[31:24];
        endcase
    end

    assign half_v = addr_i[1] ? data_i[31:16] : data_i[15:0];

    always_comb begin
        data_o = data_i;
        case (funct3_i)
            F3_LB:   data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_v};
            F3_LH:   data_o = {{(XLEN-16){half_v[15]}}, half_v};
            F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_v};
            default: data_o = data_i;
        endcase
    end

    assign misalign_o = ld_misaligned(funct3_i, addr_i);

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back select; feeds write_data_WB back
// to the MEM store-data forwarding mux.
// Inputs: clk, reset (sync, active high), valid_MEM, stall, flush, MEM data
//   (alu_result, D_out, PCadd4, funct3, wb_sel, reg_write, rd).
// Outputs: write_data_WB, rd_WB, reg_write_WB, valid_WB, load_misalign and,
//   with macro WB_RETIRE_CNT_EN defined, retire_count.
module mem_wb_stage
    import riscv_pkg::*;
`ifdef WB_RETIRE_CNT_EN
#(
    parameter int RETIRE_W = 32
)
`endif
(
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_MEM,
    input  logic                stall,
    input  logic                flush,
    input  logic [XLEN-1:0]     alu_result_MEM,
    input  logic [XLEN-1:0]     D_out_MEM,
    input  logic [XLEN-1:0]     PCadd4_MEM,
    input  logic [2:0]          funct3_MEM,
    input  logic [1:0]          wb_sel_MEM,
    input  logic                reg_write_MEM,
    input  logic [4:0]          rd_MEM,
    output logic [XLEN-1:0]     write_data_WB,
    output logic [4:0]          rd_WB,
    output logic                reg_write_WB,
    output logic                valid_WB,
`ifdef WB_RETIRE_CNT_EN
    output logic                load_misalign,
    output logic [RETIRE_W-1:0] retire_count
`else
    output logic                load_misalign
`endif
);

    logic            valid_q, valid_d;
    logic            rw_q, rw_d;
    logic            mis_q, mis_d;
    logic [4:0]      rd_q, rd_d;
    logic [1:0]      sel_q, sel_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] alu_q, alu_d;
    logic [XLEN-1:0] dout_q, dout_d;
    logic [XLEN-1:0] pc4_q, pc4_d;

    logic [XLEN-1:0] ld_data;
    logic            ld_mis;
    logic            is_ld_wb;

    always_comb begin
        valid_d = valid_q;
        rw_d    = rw_q;
        mis_d   = mis_q;
        rd_d    = rd_q;
        sel_d   = sel_q;
        f3_d    = f3_q;
        alu_d   = alu_q;
        dout_d  = dout_q;
        pc4_d   = pc4_q;
        if (flush) begin
            valid_d = 1'b0;
            rw_d    = 1'b0;
            mis_d   = 1'b0;
        end else if (!stall) begin
            valid_d = valid_MEM;
            rw_d    = reg_write_MEM;
            // Only loads can be misaligned; ALU ops reuse funct3 freely.
            mis_d   = (wb_sel_MEM == WB_MEM)
                    & ld_misaligned(funct3_MEM, alu_result_MEM[1:0]);
            rd_d    = rd_MEM;
            sel_d   = wb_sel_MEM;
            f3_d    = funct3_MEM;
            alu_d   = alu_result_MEM;
            dout_d  = D_out_MEM;
            pc4_d   = PCadd4_MEM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            mis_q   <= 1'b0;
            rd_q    <= '0;
            sel_q   <= '0;
            f3_q    <= '0;
            alu_q   <= '0;
            dout_q  <= '0;
            pc4_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rw_q    <= rw_d;
            mis_q   <= mis_d;
            rd_q    <= rd_d;
            sel_q   <= sel_d;
            f3_q    <= f3_d;
            alu_q   <= alu_d;
            dout_q  <= dout_d;
            pc4_q   <= pc4_d;
        end
    end

    load_align u_load_align (
        .data_i     (dout_q),
        .addr_i     (alu_q[1:0]),
        .funct3_i   (f3_q),
        .data_o     (ld_data),
        .misalign_o (ld_mis)
    );

    assign is_ld_wb = (sel_q == WB_MEM);

    always_comb begin
        write_data_WB = alu_q;
        case (sel_q)
            // A misaligned load never produces data.
            WB_MEM:  write_data_WB = (mis_q | ld_mis) ? '0 : ld_data;
            WB_PC4:  write_data_WB = pc4_q;
            default: write_data_WB = alu_q;
        endcase
    end

    assign rd_WB         = rd_q;
    assign valid_WB      = valid_q;
    assign reg_write_WB  = rw_q & valid_q & (rd_q != 5'd0) & ~mis_q;
    assign load_misalign = mis_q & valid_q & is_ld_wb;

`ifdef WB_RETIRE_CNT_EN
    logic [RETIRE_W-1:0] cnt_q, cnt_d;

    // An instruction retires when it leaves WB, by replacement or flush.
    always_comb begin
        cnt_d = cnt_q;
        if (valid_q && (flush || !stall)) begin
            cnt_d = cnt_q + RETIRE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retire_count = cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage against a transaction model.
// Covers load extension, misalign, stall/flush/reset and the retire counter.
module tb_mem_wb_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_MEM;
    logic        stall;
    logic        flush;
    logic [31:0] alu_result_MEM;
    logic [31:0] D_out_MEM;
    logic [31:0] PCadd4_MEM;
    logic [2:0]  funct3_MEM;
    logic [1:0]  wb_sel_MEM;
    logic        reg_write_MEM;
    logic [4:0]  rd_MEM;
    logic [31:0] write_data_WB;
    logic [4:0]  rd_WB;
    logic        reg_write_WB;
    logic        valid_WB;
    logic        load_misalign;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_count;
`endif

    mem_wb_stage dut (
        .clk            (clk),
        .reset          (reset),
        .valid_MEM      (valid_MEM),
        .stall          (stall),
        .flush          (flush),
        .alu_result_MEM (alu_result_MEM),
        .D_out_MEM      (D_out_MEM),
        .PCadd4_MEM     (PCadd4_MEM),
        .funct3_MEM     (funct3_MEM),
        .wb_sel_MEM     (wb_sel_MEM),
        .reg_write_MEM  (reg_write_MEM),
        .rd_MEM         (rd_MEM),
        .write_data_WB  (write_data_WB),
        .rd_WB          (rd_WB),
        .reg_write_WB   (reg_write_WB),
        .valid_WB       (valid_WB),
`ifdef WB_RETIRE_CNT_EN
        .load_misalign  (load_misalign),
        .retire_count   (retire_count)
`else
        .load_misalign  (load_misalign)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected WB-side view of the instruction currently in write-back.
    logic        e_valid, e_rw, e_mis, e_known;
    logic [31:0] e_wd;
    logic [4:0]  e_rd;
    logic [31:0] e_cnt;

    function automatic logic [31:0] ref_load(input logic [31:0] d,
                                             input logic [1:0] a,
                                             input logic [2:0] f3);
        logic [31:0] b, h;
        b = (d >> (8 * a)) & 32'hFF;
        h = (d >> (16 * (a / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return d;
        endcase
    endfunction

    function automatic logic ref_mis(input logic [1:0] a, input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return (a % 2) != 0;
            default:    return a != 0;
        endcase
    endfunction

    task automatic step();
        logic mis;
        @(posedge clk);
        if (reset) begin
            e_valid = 0; e_rw = 0; e_mis = 0;
            e_wd = 0; e_rd = 0; e_cnt = 0; e_known = 1;
        end else begin
            if (e_valid && (flush || !stall)) e_cnt = e_cnt + 1;
            if (flush) begin
                e_valid = 0; e_rw = 0; e_mis = 0; e_known = 0;
            end else if (!stall) begin
                mis = (wb_sel_MEM == 2'd1) && ref_mis(alu_result_MEM[1:0], funct3_MEM);
                case (wb_sel_MEM)
                    2'd1:    e_wd = mis ? 32'd0 :
                                    ref_load(D_out_MEM, alu_result_MEM[1:0], funct3_MEM);
                    2'd2:    e_wd = PCadd4_MEM;
                    default: e_wd = alu_result_MEM;
                endcase
                e_valid = valid_MEM;
                e_mis   = mis && valid_MEM;
                e_rd    = rd_MEM;
                e_rw    = reg_write_MEM && valid_MEM && rd_MEM != 0 && !mis;
                e_known = valid_MEM;
            end
        end
        #1;
        check("valid", 32'(valid_WB), 32'(e_valid));
        check("reg_write", 32'(reg_write_WB), 32'(e_rw));
        check("misalign", 32'(load_misalign), 32'(e_mis));
        if (e_known) begin
            check("wdata", write_data_WB, e_wd);
            check("rd", 32'(rd_WB), 32'(e_rd));
        end
`ifdef WB_RETIRE_CNT_EN
        check("retire", retire_count, e_cnt);
`endif
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [2:0] f3,
                         input logic rw, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] dout, input logic [31:0] pc4);
        valid_MEM = v; wb_sel_MEM = sel; funct3_MEM = f3; reg_write_MEM = rw;
        rd_MEM = rd; alu_result_MEM = alu; D_out_MEM = dout; PCadd4_MEM = pc4;
    endtask

    initial begin
        e_valid = 0; e_rw = 0; e_mis = 0; e_known = 0;
        e_wd = 0; e_rd = 0; e_cnt = 0;
        reset = 1; stall = 0; flush = 0;
        drive(1, WB_ALU, 0, 1, 3, 32'h1111, 0, 0);
        step(); step();
        check("rst_wdata", write_data_WB, 32'd0);
        check("rst_rd", 32'(rd_WB), 32'd0);
        reset = 0;

        drive(1, WB_MEM, F3_LB, 1, 5, 32'h103, 32'h80AA55CC, 0);
        step();
        check("lb_wdata", write_data_WB, 32'hFFFFFF80);
        check("lb_rd", 32'(rd_WB), 32'd5);
        check("lb_rw", 32'(reg_write_WB), 32'd1);

        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, WB_ALU, 0, 1, 9 + i, 32'h1234 + i, 0, 0);
            step();
            check("stall_wdata", write_data_WB, 32'hFFFFFF80);
            check("stall_rd", 32'(rd_WB), 32'd5);
        end
        flush = 1;
        step();
        check("fl_st_valid", 32'(valid_WB), 32'd0);
        check("fl_st_rw", 32'(reg_write_WB), 32'd0);
        flush = 0; stall = 0;

        drive(1, WB_MEM, F3_LHU, 1, 6, 32'h102, 32'h80AA55CC, 0);
        step();
        check("lhu_wdata", write_data_WB, 32'h000080AA);

        drive(1, WB_MEM, F3_LH, 1, 7, 32'h101, 32'h80AA55CC, 0);
        step();
        check("lh_mis", 32'(load_misalign), 32'd1);
        check("lh_mis_rw", 32'(reg_write_WB), 32'd0);
        check("lh_mis_wdata", write_data_WB, 32'd0);

        drive(1, WB_PC4, 0, 1, 1, 32'h55, 0, 32'h44);
        step();
        check("mis_pulse", 32'(load_misalign), 32'd0);
        check("pc4_wdata", write_data_WB, 32'h44);
        check("pc4_rw", 32'(reg_write_WB), 32'd1);
        drive(1, WB_PC4, 0, 1, 0, 32'h55, 0, 32'h44);
        step();
        check("x0_rw", 32'(reg_write_WB), 32'd0);

`ifdef WB_RETIRE_CNT_EN
        reset = 1; step(); reset = 0;
        drive(1, WB_ALU, 0, 1, 1, 1, 0, 0); step();
        drive(1, WB_ALU, 0, 1, 2, 2, 0, 0); step();
        stall = 1;
        drive(1, WB_ALU, 0, 1, 9, 9, 0, 0); step(); step();
        stall = 0;
        drive(1, WB_ALU, 0, 1, 3, 3, 0, 0); step();
        drive(1, WB_ALU, 0, 1, 4, 4, 0, 0); step();
        flush = 1;
        drive(1, WB_ALU, 0, 1, 8, 8, 0, 0); step();
        flush = 0;
        drive(1, WB_ALU, 0, 1, 5, 5, 0, 0); step();
        drive(0, WB_ALU, 0, 0, 0, 0, 0, 0); step();
        check("retire5", retire_count, 32'd5);
        drive(1, WB_ALU, 0, 1, 6, 6, 0, 0); step();
        reset = 1; step(); reset = 0;
        check("rst_mid_retire", retire_count, 32'd0);
        check("rst_mid_valid", 32'(valid_WB), 32'd0);
        check("rst_mid_wdata", write_data_WB, 32'd0);
`endif

        for (int i = 0; i < 600; i++) begin
            reset = ($urandom % 60) == 0;
            stall = ($urandom % 5) == 0;
            flush = ($urandom % 10) == 0;
            drive(($urandom % 4) != 0, 2'($urandom % 4), 3'($urandom % 8),
                  1'($urandom % 2), 5'($urandom % 32), $urandom, $urandom, $urandom);
            step();
        end
        reset = 0; stall = 0; flush = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
